// File: rtl/pe_row_feeder.sv
// pe_row_feeder: upstream sequencer for one row-stationary MAC PE.
// Loads one filter row and one ifmap row into local scratchpads. It then streams
// (image, weight, psum) triples to an external 1-cycle registered MAC PE to compute
// a 1-D valid convolution, and emits one finished psum per output position
// on a valid/ready stream.
// Optional feature macro: PSUM_CHAIN_EN. When it is defined, the initial psum of each
// output position is taken from an upstream psin valid/ready stream instead of zero.
module pe_row_feeder #(
    parameter int DATA_W    = 16,
    parameter int PSUM_W    = 32,
    parameter int FILT_LEN  = 3,
    parameter int IFMAP_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] pe_image_val,
    output logic [DATA_W-1:0] pe_weight_val,
    output logic [PSUM_W-1:0] pe_psum_in,
    input  logic [PSUM_W-1:0] pe_psum_out,
    output logic [PSUM_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef PSUM_CHAIN_EN
    ,
    input  logic [PSUM_W-1:0] psin_data,
    input  logic              psin_valid,
    output logic              psin_ready
`endif
);

    localparam int N_OUT       = IFMAP_LEN - FILT_LEN + 1;
    localparam int FIDX_W      = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int IIDX_W      = (IFMAP_LEN > 1) ? $clog2(IFMAP_LEN) : 1;
    localparam int FILT_DEPTH  = 1 << FIDX_W;
    localparam int IFMAP_DEPTH = 1 << IIDX_W;

    localparam logic [FIDX_W-1:0] S_LAST     = FIDX_W'(FILT_LEN - 1);
    localparam logic [IIDX_W-1:0] FILT_LAST  = IIDX_W'(FILT_LEN - 1);
    localparam logic [IIDX_W-1:0] IFMAP_LAST = IIDX_W'(IFMAP_LEN - 1);
    localparam logic [IIDX_W-1:0] O_LAST     = IIDX_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_I  = 3'd2,
        COMPUTE = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t              state_r;
    logic [IIDX_W-1:0]   load_cnt_r;
    logic [IIDX_W-1:0]   o_cnt_r;
    logic [FIDX_W-1:0]   s_cnt_r;
    logic                out_valid_r;
    logic                out_first_r;
    logic                done_r;
    logic [PSUM_W-1:0]   out_data_r;

    logic [DATA_W-1:0]   filt_mem  [FILT_DEPTH];
    logic [DATA_W-1:0]   ifmap_mem [IFMAP_DEPTH];

    logic                beat_s;
    logic                issue_s;
    logic [IIDX_W-1:0]   pos_s;
    logic [PSUM_W-1:0]   init_psum_s;

    assign busy      = (state_r != IDLE);
    assign in_ready  = (state_r == LOAD_W) || (state_r == LOAD_I);
    assign beat_s    = in_valid && in_ready;
    assign done      = done_r;
    assign out_valid = out_valid_r;
    // The PE result becomes final on the same edge that moves us into OUT, so
    // in the OUT entry cycle it is forwarded directly. It is captured into out_data_r
    // at the end of that cycle, which keeps out_data stable for any backpressure stall.
    assign out_data  = out_first_r ? pe_psum_out : out_data_r;
    assign pos_s     = o_cnt_r + IIDX_W'(s_cnt_r);

`ifdef PSUM_CHAIN_EN
    assign init_psum_s = psin_data;
`else
    assign init_psum_s = {PSUM_W{1'b0}};
`endif

    // Scratchpad writes: load beat k lands at index k; contents survive reset.
    always_ff @(posedge clk) begin
        if (beat_s && (state_r == LOAD_W)) begin
            filt_mem[load_cnt_r[FIDX_W-1:0]] <= in_data;
        end
        if (beat_s && (state_r == LOAD_I)) begin
            ifmap_mem[load_cnt_r] <= in_data;
        end
    end

    // MAC issue decode: drive the PE only on cycles that actually issue a MAC.
    always_comb begin
        issue_s       = 1'b0;
        pe_image_val  = {DATA_W{1'b0}};
        pe_weight_val = {DATA_W{1'b0}};
        pe_psum_in    = {PSUM_W{1'b0}};
`ifdef PSUM_CHAIN_EN
        psin_ready    = 1'b0;
`endif
        if (state_r == COMPUTE) begin
            if (s_cnt_r == {FIDX_W{1'b0}}) begin
`ifdef PSUM_CHAIN_EN
                psin_ready = 1'b1;
                issue_s    = psin_valid;
`else
                issue_s    = 1'b1;
`endif
            end else begin
                issue_s = 1'b1;
            end
            if (issue_s) begin
                pe_image_val  = ifmap_mem[pos_s];
                pe_weight_val = filt_mem[s_cnt_r];
                pe_psum_in    = (s_cnt_r == {FIDX_W{1'b0}}) ? init_psum_s : pe_psum_out;
            end else begin
                pe_image_val  = {DATA_W{1'b0}};
                pe_weight_val = {DATA_W{1'b0}};
                pe_psum_in    = {PSUM_W{1'b0}};
            end
        end else begin
            issue_s = 1'b0;
        end
    end

    // Main sequencer FSM with counters and registered stream/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            load_cnt_r  <= {IIDX_W{1'b0}};
            o_cnt_r     <= {IIDX_W{1'b0}};
            s_cnt_r     <= {FIDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_first_r <= 1'b0;
            done_r      <= 1'b0;
            out_data_r  <= {PSUM_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r    <= LOAD_W;
                        load_cnt_r <= {IIDX_W{1'b0}};
                    end
                end
                LOAD_W: begin
                    if (beat_s) begin
                        if (load_cnt_r == FILT_LAST) begin
                            load_cnt_r <= {IIDX_W{1'b0}};
                            state_r    <= LOAD_I;
                        end else begin
                            load_cnt_r <= load_cnt_r + IIDX_W'(1);
                        end
                    end
                end
                LOAD_I: begin
                    if (beat_s) begin
                        if (load_cnt_r == IFMAP_LAST) begin
                            load_cnt_r <= {IIDX_W{1'b0}};
                            s_cnt_r    <= {FIDX_W{1'b0}};
                            o_cnt_r    <= {IIDX_W{1'b0}};
                            state_r    <= COMPUTE;
                        end else begin
                            load_cnt_r <= load_cnt_r + IIDX_W'(1);
                        end
                    end
                end
                COMPUTE: begin
                    if (issue_s) begin
                        if (s_cnt_r == S_LAST) begin
                            s_cnt_r     <= {FIDX_W{1'b0}};
                            state_r     <= OUT;
                            out_valid_r <= 1'b1;
                            out_first_r <= 1'b1;
                        end else begin
                            s_cnt_r <= s_cnt_r + FIDX_W'(1);
                        end
                    end
                end
                OUT: begin
                    out_first_r <= 1'b0;
                    if (out_first_r) begin
                        out_data_r <= pe_psum_out;
                    end
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        if (o_cnt_r == O_LAST) begin
                            o_cnt_r <= {IIDX_W{1'b0}};
                            state_r <= IDLE;
                            done_r  <= 1'b1;
                        end else begin
                            o_cnt_r <= o_cnt_r + IIDX_W'(1);
                            state_r <= COMPUTE;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    out_first_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_row_feeder.sv
// Testbench for pe_row_feeder: table-driven runs plus hand-written reset and
// psum-chain sequences. Contains a behavioural model of the 1-cycle MAC PE.
module tb_pe_row_feeder;

    localparam int DW = 16;
    localparam int PW = 32;
    localparam int S  = 3;
    localparam int W  = 8;
    localparam int N  = W - S + 1;
    localparam int NV = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          busy, done;
    logic [DW-1:0] in_data = 16'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] pe_image_val, pe_weight_val;
    logic [PW-1:0] pe_psum_in;
    logic [PW-1:0] pe_psum_out = 32'd0;
    logic [PW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
`ifdef PSUM_CHAIN_EN
    logic [PW-1:0] psin_data = 32'd0;
    logic          psin_valid = 1'b1;
    logic          psin_ready;
`endif

    int checks = 0;
    int errors = 0;
    int tick = 0;

    typedef struct {
        logic [S-1:0][DW-1:0] filt;
        logic [W-1:0][DW-1:0] img;
        logic [N-1:0][PW-1:0] exp;
        bit                   bubbles;
        int                   stall_o;
        int                   stall_n;
        bit                   check_lat;
    } vec_t;

    vec_t tv [NV];
    vec_t cv;

    pe_row_feeder #(
        .DATA_W(DW), .PSUM_W(PW), .FILT_LEN(S), .IFMAP_LEN(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .pe_image_val(pe_image_val),
        .pe_weight_val(pe_weight_val),
        .pe_psum_in(pe_psum_in),
        .pe_psum_out(pe_psum_out),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef PSUM_CHAIN_EN
        ,
        .psin_data(psin_data),
        .psin_valid(psin_valid),
        .psin_ready(psin_ready)
`endif
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) tick <= tick + 1;

    // Behavioural PE: registered unsigned MAC, wraps modulo 2^32.
    always @(posedge clk)
        pe_psum_out <= {16'd0, pe_image_val} * {16'd0, pe_weight_val} + pe_psum_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_row(input vec_t v);
        for (int j = 0; j < S + W; j++) begin
            if (v.bubbles) begin
                in_valid = 1'b0;
                in_data  = 16'hBEEF;
                start    = 1'b1;          // start while busy must be ignored
                @(negedge clk);
                start    = 1'b0;
            end
            chk("in_ready_load", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b1;
            in_data  = (j < S) ? v.filt[j] : v.img[j - S];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 16'd0;
    endtask

    task automatic do_run(input vec_t v);
        int t0;
        int to;
        @(negedge clk);
        chk("busy_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        t0 = tick;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        load_row(v);
        chk("in_ready_compute", {31'd0, in_ready}, 32'd0);
        for (int o = 0; o < N; o++) begin
            out_ready = (o == v.stall_o) ? 1'b0 : 1'b1;
            to = 0;
            while (!out_valid && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (!out_valid) begin
                chk("out_valid_timeout", 32'd0, 32'd1);
                out_ready = 1'b1;
                return;
            end
            if (o == v.stall_o) begin
                for (int k = 0; k < v.stall_n; k++) begin
                    chk($sformatf("held_data[%0d]", o), out_data, v.exp[o]);
                    chk("held_valid", {31'd0, out_valid}, 32'd1);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
            chk($sformatf("out_data[%0d]", o), out_data, v.exp[o]);
            chk("done_mid", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (v.check_lat) chk("run_latency", tick - t0, 32'd36);
        @(negedge clk);
        chk("done_cleared", {31'd0, done}, 32'd0);
    endtask

`ifdef PSUM_CHAIN_EN
    task automatic psin_drv();
        int to;
        for (int j = 0; j < N; j++) begin
            to = 0;
            while (!psin_ready && to < 100) begin
                @(negedge clk);
                to++;
            end
            if (!psin_ready) begin
                chk("psin_ready_timeout", 32'd0, 32'd1);
                return;
            end
            @(negedge clk);
            chk("stall_weight_zero", {16'd0, pe_weight_val}, 32'd0);
            chk("stall_psin_ready", {31'd0, psin_ready}, 32'd1);
            @(negedge clk);
            psin_valid = 1'b1;
            psin_data  = 32'd100 * (j + 1);
            @(negedge clk);
            psin_valid = 1'b0;
        end
    endtask
`endif

    initial begin
        // Vector table; in each packed concatenation, element 0 is the rightmost.
        tv[0].filt = {16'd3, 16'd2, 16'd1};
        tv[0].img  = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        tv[0].exp  = {32'd44, 32'd38, 32'd32, 32'd26, 32'd20, 32'd14};
        tv[0].bubbles = 1'b0; tv[0].stall_o = -1; tv[0].stall_n = 0; tv[0].check_lat = 1'b1;
        tv[1] = tv[0];
        tv[1].stall_o = 2; tv[1].stall_n = 5; tv[1].check_lat = 1'b0;
        tv[2] = tv[0];
        tv[2].bubbles = 1'b1; tv[2].check_lat = 1'b0;
        tv[3].filt = {16'hFFFF, 16'hFFFF, 16'hFFFF};
        tv[3].img  = {8{16'hFFFF}};
        tv[3].exp  = {6{32'hFFFA0003}};
        tv[3].bubbles = 1'b0; tv[3].stall_o = -1; tv[3].stall_n = 0; tv[3].check_lat = 1'b1;
        tv[4].filt = {16'd1, 16'd0, 16'd2};
        tv[4].img  = {16'd9, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
        tv[4].exp  = {32'd9, 32'd9, 32'd4, 32'd7, 32'd10, 32'd13};
        tv[4].bubbles = 1'b0; tv[4].stall_o = -1; tv[4].stall_n = 0; tv[4].check_lat = 1'b1;
        tv[5].filt = {16'd30, 16'd20, 16'd10};
        tv[5].img  = {16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        tv[5].exp  = {32'd60, 32'd0, 32'd0, 32'd0, 32'd0, 32'd10};
        tv[5].bubbles = 1'b0; tv[5].stall_o = 0; tv[5].stall_n = 2; tv[5].check_lat = 1'b0;

        // Reset state.
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_pe_image", {16'd0, pe_image_val}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset in the middle of COMPUTE abandons the run.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_row(tv[0]);
        @(negedge clk);
        chk("pre_rst_image", {16'd0, pe_image_val}, 32'd2);
        rst = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_image", {16'd0, pe_image_val}, 32'd0);
        chk("midrst_weight", {16'd0, pe_weight_val}, 32'd0);
        chk("midrst_psum_in", pe_psum_in, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) do_run(tv[i]);

`ifdef PSUM_CHAIN_EN
        cv = tv[0];
        cv.exp = {32'd644, 32'd538, 32'd432, 32'd326, 32'd220, 32'd114};
        cv.check_lat = 1'b0;
        psin_valid = 1'b0;
        psin_data  = 32'd0;
        fork
            do_run(cv);
            psin_drv();
        join
        psin_valid = 1'b1;
        psin_data  = 32'd0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
